fetch_store_ctrl: RTL and testbench

FETCH_STORE_CTRL -- requirements
Module: fetch_store_ctrl

---
 rtl/fetch_store_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fetch_store_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_store_ctrl.sv
// Command sequencer for Data_Fetch: walks the enabled PEs and their sub-passes,
// arming a LOAD or STORE transfer for each and reporting completion or timeout.
module fetch_store_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [1:0] cmd_dimen,
  input  logic [3:0] cmd_addr,
  input  logic [3:0] cmd_pe_mask,
  input  logic       fetch_done,
  input  logic       store_done,
  output logic [1:0] dimen,
  output logic [3:0] address,
  output logic [1:0] pe_sel,
  output logic       pe_sel_2x2,
  output logic       pe_sel_4,
  output logic       addr_start,
  output logic       wraddr_start,
  output logic       addr_rst,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, NEXT, FINISH} state_t;

  state_t     state, state_next;
  logic       op_q, op_next;
  logic [1:0] dimen_q, dimen_next;
  logic [3:0] addr_q, addr_next;
  logic [3:0] mask_q, mask_next;
  logic [1:0] pe_q, pe_next;
  logic [1:0] sub_q, sub_next;
  logic [7:0] wd_q, wd_next;
  logic       err_q, err_next;

  logic [1:0] first_pe;
  logic [1:0] later_pe;
  logic       later_found;
  logic [1:0] last_sub;
  logic       run_done;

  // Lowest set bit of the incoming mask; descending scan so the lowest wins.
  always_comb begin
    first_pe = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cmd_pe_mask[i]) first_pe = 2'(i);
    end
  end

  always_comb begin
    later_found = 1'b0;
    later_pe    = pe_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > pe_q)) begin
        later_found = 1'b1;
        later_pe    = 2'(i);
      end
    end
  end

  always_comb begin
    case (dimen_q)
      2'b00:   last_sub = 2'd0;
      2'b01:   last_sub = 2'd1;
      default: last_sub = 2'd3;
    endcase
  end

  assign run_done = op_q ? store_done : fetch_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= 1'b0;
      dimen_q <= 2'd0;
      addr_q  <= 4'd0;
      mask_q  <= 4'd0;
      pe_q    <= 2'd0;
      sub_q   <= 2'd0;
      wd_q    <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      dimen_q <= dimen_next;
      addr_q  <= addr_next;
      mask_q  <= mask_next;
      pe_q    <= pe_next;
      sub_q   <= sub_next;
      wd_q    <= wd_next;
      err_q   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    dimen_next = dimen_q;
    addr_next  = addr_q;
    mask_next  = mask_q;
    pe_next    = pe_q;
    sub_next   = sub_q;
    wd_next    = wd_q;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op;
          dimen_next = cmd_dimen;
          addr_next  = cmd_addr;
          mask_next  = cmd_pe_mask;
          pe_next    = first_pe;
          sub_next   = 2'd0;
          wd_next    = 8'd0;
          err_next   = (cmd_dimen == 2'b11);
          // Reserved size or empty mask completes without touching Data_Fetch.
          if (cmd_dimen == 2'b11 || cmd_pe_mask == 4'd0) state_next = FINISH;
          else                                            state_next = ARM;
        end
      end
      ARM: begin
        wd_next    = 8'd0;
        state_next = RUN;
      end
      RUN: begin
        if (run_done) begin
          state_next = NEXT;
        end else if (({1'b0, wd_q} + 9'd1) >= 9'(TIMEOUT)) begin
          err_next   = 1'b1;
          state_next = FINISH;
        end else begin
          wd_next = wd_q + 8'd1;
        end
      end
      NEXT: begin
        if (sub_q != last_sub) begin
          sub_next   = sub_q + 2'd1;
          state_next = ARM;
        end else if (later_found) begin
          pe_next    = later_pe;
          sub_next   = 2'd0;
          state_next = ARM;
        end else begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign cmd_done     = (state == FINISH);
  assign cmd_err      = (state == FINISH) && err_q;
  assign addr_rst     = rst || (state == ARM);
  assign addr_start   = (state == RUN) && !op_q;
  assign wraddr_start = (state == RUN) && op_q;
  assign dimen        = dimen_q;
  assign address      = addr_q;
  assign pe_sel       = pe_q;
  assign pe_sel_4     = sub_q[1];
  assign pe_sel_2x2   = sub_q[0];

endmodule

// File: tb/tb_fetch_store_ctrl.sv
// Directed bench for fetch_store_ctrl; DUT built with TIMEOUT=4 so the
// watchdog path is reachable while normal passes finish within 3 RUN cycles.
module tb_fetch_store_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [1:0] cmd_dimen = 2'd0;
  logic [3:0] cmd_addr = 4'd0;
  logic [3:0] cmd_pe_mask = 4'd0;
  logic       fetch_done = 1'b0;
  logic       store_done = 1'b0;
  logic [1:0] dimen;
  logic [3:0] address;
  logic [1:0] pe_sel;
  logic       pe_sel_2x2;
  logic       pe_sel_4;
  logic       addr_start;
  logic       wraddr_start;
  logic       addr_rst;
  logic       busy;
  logic       cmd_done;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  int arm_cnt, as_cnt, ws_cnt, done_cnt;
  logic [3:0] pass_log[$];

  fetch_store_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dimen(cmd_dimen), .cmd_addr(cmd_addr),
    .cmd_pe_mask(cmd_pe_mask), .fetch_done(fetch_done), .store_done(store_done),
    .dimen(dimen), .address(address), .pe_sel(pe_sel), .pe_sel_2x2(pe_sel_2x2),
    .pe_sel_4(pe_sel_4), .addr_start(addr_start), .wraddr_start(wraddr_start),
    .addr_rst(addr_rst), .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Mid-cycle activity monitor; each ARM cycle logs {pe_sel, sub-pass}.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_rst) begin
        arm_cnt++;
        pass_log.push_back({pe_sel, pe_sel_4, pe_sel_2x2});
      end
      if (addr_start)   as_cnt++;
      if (wraddr_start) ws_cnt++;
      if (cmd_done)     done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation hung");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    arm_cnt = 0; as_cnt = 0; ws_cnt = 0; done_cnt = 0;
    pass_log.delete();
  endtask

  task automatic issue(input logic op, input logic [1:0] dm, input logic [3:0] ad,
                       input logic [3:0] mk);
    cmd_op = op; cmd_dimen = dm; cmd_addr = ad; cmd_pe_mask = mk;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Answers each pass with the matching done in RUN cycle k.
  task automatic serve(input bit is_store, input int k, input int passes);
    for (int p = 0; p < passes; p++) begin
      int n = 0;
      while (!(addr_start || wraddr_start) && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (!(addr_start || wraddr_start)) begin
        errors++;
        $display("[TB] FAIL serve_wait_run pass %0d: start=0 required 1", p);
        return;
      end
      repeat (k - 1) tick();
      if (is_store) store_done = 1'b1; else fetch_done = 1'b1;
      tick();
      if (is_store) store_done = 1'b0; else fetch_done = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!cmd_done && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_wait_done cmd_done=%b required 1", name, cmd_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, busy, cmd_done, cmd_err, addr_start, wraddr_start, addr_rst} !== 7'b1000001) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b required 1000001",
               {cmd_ready, busy, cmd_done, cmd_err, addr_start, wraddr_start, addr_rst});
    end
    checks++;
    if ({dimen, address, pe_sel, pe_sel_2x2, pe_sel_4} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs got %h required 000",
               {dimen, address, pe_sel, pe_sel_2x2, pe_sel_4});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (addr_rst !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release addr_rst=%b required 0", addr_rst);
    end
    fetch_done = 1'b1;
    store_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    store_done = 1'b0;
    checks++;
    if ({cmd_ready, busy, cmd_done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL idle_done_ignored got %b required 100", {cmd_ready, busy, cmd_done});
    end
  endtask

  task automatic test_load_2x2();
    clear_counts();
    issue(1'b0, 2'b00, 4'hA, 4'b0001);
    checks++;
    if ({addr_rst, addr_start, wraddr_start, busy, cmd_ready, pe_sel, address} !== {5'b10010, 2'd0, 4'hA}) begin
      errors++;
      $display("[TB] FAIL load2_arm got %b required 1001000%b",
               {addr_rst, addr_start, wraddr_start, busy, cmd_ready, pe_sel, address}, 4'hA);
    end
    cmd_valid = 1'b1; cmd_addr = 4'h5; cmd_op = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({addr_rst, addr_start, wraddr_start} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL load2_run got %b required 010", {addr_rst, addr_start, wraddr_start});
    end
    tick();
    tick();
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    checks++;
    if ({addr_start, cmd_done, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL load2_next got %b required 001", {addr_start, cmd_done, busy});
    end
    tick();
    checks++;
    if ({cmd_done, cmd_err} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL load2_finish got %b required 10", {cmd_done, cmd_err});
    end
    tick();
    checks++;
    if ({cmd_ready, cmd_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL load2_ready got %b required 10", {cmd_ready, cmd_done});
    end
    tick();
    checks++;
    if ({cmd_ready, busy, address} !== {2'b10, 4'hA}) begin
      errors++;
      $display("[TB] FAIL load2_not_queued got %b required 10%b", {cmd_ready, busy, address}, 4'hA);
    end
    checks++;
    if (arm_cnt != 1 || as_cnt != 3 || ws_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL load2_counts arm=%0d as=%0d ws=%0d done=%0d required 1 3 0 1",
               arm_cnt, as_cnt, ws_cnt, done_cnt);
    end
  endtask

  task automatic test_load_8x8();
    int bad = 0;
    clear_counts();
    issue(1'b0, 2'b10, 4'h5, 4'b1111);
    checks++;
    if ({dimen, address} !== {2'b10, 4'h5}) begin
      errors++;
      $display("[TB] FAIL load8_latch got %b required 100101", {dimen, address});
    end
    serve(1'b0, 1, 16);
    wait_done("load8");
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load8_err cmd_err=%b required 0", cmd_err);
    end
    tick();
    checks++;
    if (arm_cnt != 16 || as_cnt != 16 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL load8_counts arm=%0d as=%0d done=%0d required 16 16 1",
               arm_cnt, as_cnt, done_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      logic [1:0] pe_exp = 2'(i / 4);
      logic [1:0] sub_exp = 2'(i % 4);
      if (i >= pass_log.size() || pass_log[i] !== {pe_exp, sub_exp}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL load8_order bad_entries=%0d required 0 (log size %0d)", bad, pass_log.size());
    end
  endtask

  task automatic test_store_4x4();
    clear_counts();
    fetch_done = 1'b1;
    issue(1'b1, 2'b01, 4'h3, 4'b1010);
    checks++;
    if (pe_sel !== 2'd1) begin
      errors++;
      $display("[TB] FAIL store4_first_pe pe_sel=%0d required 1", pe_sel);
    end
    serve(1'b1, 2, 4);
    wait_done("store4");
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store4_err cmd_err=%b required 0", cmd_err);
    end
    fetch_done = 1'b0;
    tick();
    checks++;
    if (arm_cnt != 4 || ws_cnt != 8 || as_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL store4_counts arm=%0d ws=%0d as=%0d done=%0d required 4 8 0 1",
               arm_cnt, ws_cnt, as_cnt, done_cnt);
    end
    checks++;
    if (pass_log.size() != 4 || pass_log[0] !== 4'b0100 || pass_log[1] !== 4'b0101 ||
        pass_log[2] !== 4'b1100 || pass_log[3] !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL store4_order size=%0d required 4 with passes 0100 0101 1100 1101",
               pass_log.size());
    end
  endtask

  task automatic test_timeout();
    int c = 0;
    clear_counts();
    issue(1'b0, 2'b00, 4'h1, 4'b0001);
    tick();
    while (addr_start && c < 20) begin
      c++;
      tick();
    end
    checks++;
    if (c != 4) begin
      errors++;
      $display("[TB] FAIL timeout_run_len cycles=%0d required 4", c);
    end
    checks++;
    if ({cmd_done, cmd_err} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL timeout_err got %b required 11", {cmd_done, cmd_err});
    end
    tick();
    checks++;
    if ({cmd_ready, cmd_err} !== 2'b10 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL timeout_idle got %b done=%0d required 10 1", {cmd_ready, cmd_err}, done_cnt);
    end
  endtask

  task automatic test_reserved_and_empty();
    clear_counts();
    issue(1'b0, 2'b11, 4'h2, 4'b0001);
    checks++;
    if ({cmd_done, cmd_err, addr_rst} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL reserved_dimen got %b required 110", {cmd_done, cmd_err, addr_rst});
    end
    tick();
    issue(1'b0, 2'b00, 4'h2, 4'b0000);
    checks++;
    if ({cmd_done, cmd_err, addr_rst} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL empty_mask got %b required 100", {cmd_done, cmd_err, addr_rst});
    end
    tick();
    checks++;
    if (arm_cnt != 0 || as_cnt != 0 || done_cnt != 2 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reserved_counts arm=%0d as=%0d done=%0d ready=%b required 0 0 2 1",
               arm_cnt, as_cnt, done_cnt, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_counts();
    issue(1'b0, 2'b10, 4'h9, 4'b1111);
    serve(1'b0, 1, 2);
    tick();
    tick();
    checks++;
    if ({addr_start, pe_sel_4, pe_sel_2x2} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL midrst_pre got %b required 110", {addr_start, pe_sel_4, pe_sel_2x2});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, busy, addr_start, wraddr_start, cmd_done, addr_rst} !== 6'b100001) begin
      errors++;
      $display("[TB] FAIL midrst_state got %b required 100001",
               {cmd_ready, busy, addr_start, wraddr_start, cmd_done, addr_rst});
    end
    checks++;
    if ({pe_sel, pe_sel_4, pe_sel_2x2, dimen, address} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL midrst_regs got %h required 000", {pe_sel, pe_sel_4, pe_sel_2x2, dimen, address});
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt != 0 || cmd_ready !== 1'b1 || addr_rst !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_no_done done=%0d ready=%b addr_rst=%b required 0 1 0",
               done_cnt, cmd_ready, addr_rst);
    end
    clear_counts();
    issue(1'b0, 2'b00, 4'h7, 4'b0100);
    serve(1'b0, 2, 1);
    wait_done("midrst_new");
    checks++;
    if ({cmd_err, pe_sel} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL midrst_new_cmd got %b required 010", {cmd_err, pe_sel});
    end
    tick();
    checks++;
    if (arm_cnt != 1 || as_cnt != 2 || pass_log.size() != 1 || pass_log[0] !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL midrst_new_counts arm=%0d as=%0d required 1 2 with pass 1000", arm_cnt, as_cnt);
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_load_2x2();
    test_load_8x8();
    test_store_4x4();
    test_timeout();
    test_reserved_and_empty();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
